// File: rtl/dvp_capture_if.sv
// Frame-buffer write-side bus driven by the DVP capture stage.
// Handshake: de is a pure valid strobe with no ready/back-pressure; the
// frame buffer must accept data on every cycle where de=1, and vs_n (active
// low) marks the frame sync that precedes the first line of a frame.
interface dvp_capture_if;
  logic        vs_n;
  logic        de;
  logic [15:0] data;

  modport master (output vs_n, output de, output data);
  modport slave  (input  vs_n, input  de, input  data);
endinterface

// File: rtl/dvp_capture.sv
// DVP camera capture: registers sensor VSYNC/HREF/PIXDATA, skips start-up
// frames, packs RAW10 or 2-byte RGB565 into 16-bit pixels and reports
// frame/line status plus sticky geometry error flags.
module dvp_capture #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int SKIP_FRAMES = 2
) (
  input  logic                I_clk,
  input  logic                I_rst_n,
  input  logic                I_enable,
  input  logic                I_mode,
  input  logic                I_vsync,
  input  logic                I_href,
  input  logic [9:0]          I_pixdata,
  dvp_capture_if.master       O_fb,
  output logic                O_locked,
  output logic [7:0]          O_frame_cnt,
  output logic                O_line_err,
  output logic                O_frame_err,
  output logic [1:0]          O_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SKIP = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [11:0] LP_H_RES = 12'(H_RES);
  localparam logic [11:0] LP_V_RES = 12'(V_RES);
  localparam logic [7:0]  LP_SKIP  = 8'(SKIP_FRAMES);

  // input sampling stage
  logic        r_vs_d;
  logic        r_vs_q;
  logic        r_href_d;
  logic        r_href_q;
  logic [9:0]  r_pix_d;

  // control
  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_skip_cnt;
  logic [7:0]  w_skip_next;
  logic        w_clr_err;

  // datapath
  logic        r_phase;
  logic [7:0]  r_b0;
  logic        r_de;
  logic [15:0] r_data;
  logic        r_vs_n;
  logic [11:0] r_px_cnt;
  logic [11:0] r_line_cnt;
  logic [7:0]  r_frame_cnt;
  logic        r_line_err;
  logic        r_frame_err;

  logic        w_boundary;
  logic        w_href_fall;
  logic        w_run;
  logic        w_frame_close;
  logic        w_de_next;
  logic [15:0] w_data_next;
  logic        w_unused;

  assign w_boundary    = r_vs_d & ~r_vs_q;
  assign w_href_fall   = ~r_href_d & r_href_q;
  assign w_run         = (r_state == ST_RUN);
  assign w_frame_close = w_boundary & w_run;

  // RAW10 emits every HREF cycle; RGB565 only on the second byte.
  // VSYNC high gates data so a line overlapping the frame edge is dropped.
  assign w_de_next   = w_run & r_href_d & ~r_vs_d & (~I_mode | r_phase);
  assign w_data_next = I_mode ? {r_b0, r_pix_d[9:2]}
                              : {r_pix_d[9:5], r_pix_d[9:4], r_pix_d[9:5]};

  // the two LSBs of PIXDATA carry no information in either packing
  assign w_unused = ^r_pix_d[1:0];

  // single register stage on all sensor inputs plus edge-detect history
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_vs_d   <= 1'b0;
      r_vs_q   <= 1'b0;
      r_href_d <= 1'b0;
      r_href_q <= 1'b0;
      r_pix_d  <= '0;
    end else begin
      r_vs_d   <= I_vsync;
      r_vs_q   <= r_vs_d;
      r_href_d <= I_href;
      r_href_q <= r_href_d;
      r_pix_d  <= I_pixdata;
    end
  end

  // FSM state and skip counter registers
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state    <= ST_IDLE;
      r_skip_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_skip_cnt <= w_skip_next;
    end
  end

  // next-state logic: decisions are taken only at frame boundaries
  always_comb begin
    w_state_next = r_state;
    w_skip_next  = r_skip_cnt;
    w_clr_err    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_boundary && I_enable) begin
          w_skip_next = '0;
          if (SKIP_FRAMES > 0) begin
            w_state_next = ST_SKIP;
          end else begin
            w_state_next = ST_RUN;
            w_clr_err    = 1'b1;
          end
        end
      end
      ST_SKIP: begin
        if (w_boundary) begin
          if (!I_enable) begin
            w_state_next = ST_IDLE;
          end else begin
            w_skip_next = r_skip_cnt + 8'd1;
            if (w_skip_next == LP_SKIP) begin
              w_state_next = ST_RUN;
            end
          end
        end
      end
      ST_RUN: begin
        if (w_boundary && !I_enable) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // RGB565 byte phase and high-byte capture; phase restarts on every line
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_phase <= 1'b0;
      r_b0    <= '0;
    end else begin
      if (!r_href_d) begin
        r_phase <= 1'b0;
      end else if (I_mode) begin
        r_phase <= ~r_phase;
      end
      if (r_href_d && !r_phase) begin
        r_b0 <= r_pix_d[9:2];
      end
    end
  end

  // output strobes; vs_n follows VSYNC only once the frame is being delivered
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_de   <= 1'b0;
      r_data <= '0;
      r_vs_n <= 1'b1;
    end else begin
      r_de   <= w_de_next;
      if (w_de_next) begin
        r_data <= w_data_next;
      end
      r_vs_n <= ~((w_state_next == ST_RUN) & r_vs_d);
    end
  end

  // pixel-per-line and line-per-frame counters
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_px_cnt   <= '0;
      r_line_cnt <= '0;
    end else begin
      if (w_href_fall) begin
        r_px_cnt <= '0;
      end else if (w_de_next) begin
        r_px_cnt <= r_px_cnt + 12'd1;
      end
      if (w_boundary) begin
        r_line_cnt <= '0;
      end else if (w_href_fall && w_run) begin
        r_line_cnt <= r_line_cnt + 12'd1;
      end
    end
  end

  // frame counter and sticky geometry errors, evaluated at line/frame close
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_frame_cnt <= '0;
      r_line_err  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_frame_close) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
      if (w_clr_err) begin
        r_line_err <= 1'b0;
      end else if (w_href_fall && w_run && (r_px_cnt != LP_H_RES)) begin
        r_line_err <= 1'b1;
      end
      if (w_clr_err) begin
        r_frame_err <= 1'b0;
      end else if (w_frame_close && (r_line_cnt != LP_V_RES)) begin
        r_frame_err <= 1'b1;
      end
    end
  end

  assign O_fb.vs_n   = r_vs_n;
  assign O_fb.de     = r_de;
  assign O_fb.data   = r_data;
  assign O_locked    = w_run;
  assign O_frame_cnt = r_frame_cnt;
  assign O_line_err  = r_line_err;
  assign O_frame_err = r_frame_err;
  assign O_dbg_state = r_state;

endmodule

// File: tb/tb_dvp_capture.sv
// Bench for dvp_capture: drives small DVP frames and checks packed pixels,
// latency, lock/skip sequencing, counters and sticky error flags.
module tb_dvp_capture;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int SK = 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SKIP = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic       I_clk     = 1'b0;
  logic       I_rst_n   = 1'b0;
  logic       I_enable  = 1'b0;
  logic       I_mode    = 1'b0;
  logic       I_vsync   = 1'b0;
  logic       I_href    = 1'b0;
  logic [9:0] I_pixdata = '0;
  logic       O_locked;
  logic [7:0] O_frame_cnt;
  logic       O_line_err;
  logic       O_frame_err;
  logic [1:0] O_dbg_state;

  dvp_capture_if fb_if ();

  dvp_capture #(.H_RES(H), .V_RES(V), .SKIP_FRAMES(SK)) dut (
    .I_clk       (I_clk),
    .I_rst_n     (I_rst_n),
    .I_enable    (I_enable),
    .I_mode      (I_mode),
    .I_vsync     (I_vsync),
    .I_href      (I_href),
    .I_pixdata   (I_pixdata),
    .O_fb        (fb_if),
    .O_locked    (O_locked),
    .O_frame_cnt (O_frame_cnt),
    .O_line_err  (O_line_err),
    .O_frame_err (O_frame_err),
    .O_dbg_state (O_dbg_state)
  );

  // clock / cycle counter
  always #5 I_clk = ~I_clk;

  int cyc = 0;
  always @(posedge I_clk) cyc <= cyc + 1;

  // scoreboard
  logic [15:0] exp_q[$];
  int          t_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mon_en = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] raw_exp(input logic [9:0] p);
    return {p[9:5], p[9:4], p[9:5]};
  endfunction

  // output monitor: every de must match the head of the expected queue
  logic [15:0] mon_e;
  int          mon_t;
  always @(posedge I_clk) begin
    #1;
    if (mon_en && fb_if.de) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_de", {31'd0, fb_if.de}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = t_q.pop_front();
        check_eq("pix_data", {16'd0, fb_if.data}, {16'd0, mon_e});
        check_eq("pix_latency", cyc - mon_t, 32'd2);
      end
    end
  end

  // driver tasks
  task automatic gap(input int n);
    repeat (n) begin
      @(negedge I_clk);
      I_href    = 1'b0;
      I_vsync   = 1'b0;
      I_pixdata = '0;
    end
  endtask

  task automatic vsync_pulse(input logic [1:0] exp_state);
    repeat (3) begin
      @(negedge I_clk);
      I_vsync = 1'b1;
      I_href  = 1'b0;
    end
    @(negedge I_clk);
    check_eq("vs_state", {30'd0, O_dbg_state}, {30'd0, exp_state});
    check_eq("vs_locked", {31'd0, O_locked}, {31'd0, exp_state == S_RUN});
    check_eq("vs_n", {31'd0, fb_if.vs_n}, {31'd0, exp_state != S_RUN});
    I_vsync = 1'b0;
  endtask

  task automatic drive_line(input int npix, input bit deliver, input bit mode,
                            input bit use_fixed, input logic [9:0] fx_a, input logic [9:0] fx_b);
    logic [9:0] p0;
    logic [9:0] p1;
    for (int i = 0; i < npix; i++) begin
      p0 = use_fixed ? fx_a : 10'($urandom_range(0, 1023));
      p1 = use_fixed ? fx_b : 10'($urandom_range(0, 1023));
      @(negedge I_clk);
      I_href    = 1'b1;
      I_pixdata = p0;
      if (!mode) begin
        if (deliver) begin
          exp_q.push_back(raw_exp(p0));
          t_q.push_back(cyc);
        end
      end else begin
        @(negedge I_clk);
        I_pixdata = p1;
        if (deliver) begin
          exp_q.push_back({p0[9:2], p1[9:2]});
          t_q.push_back(cyc);
        end
      end
    end
  endtask

  task automatic drive_frame(input logic [1:0] exp_state, input bit deliver, input bit mode,
                             input int n_lines, input int short_line, input int drop_line,
                             input bit use_fixed, input logic [9:0] fx_a, input logic [9:0] fx_b);
    vsync_pulse(exp_state);
    gap(2);
    for (int l = 0; l < n_lines; l++) begin
      if (l == drop_line) I_enable = 1'b0;
      drive_line((l == short_line) ? H - 1 : H, deliver, mode, use_fixed, fx_a, fx_b);
      gap(3);
    end
  endtask

  // watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // main sequence
  initial begin
    repeat (3) @(negedge I_clk);
    check_eq("rst_vs_n", {31'd0, fb_if.vs_n}, 32'd1);
    check_eq("rst_de", {31'd0, fb_if.de}, 32'd0);
    check_eq("rst_data", {16'd0, fb_if.data}, 32'd0);
    check_eq("rst_locked", {31'd0, O_locked}, 32'd0);
    check_eq("rst_frame_cnt", {24'd0, O_frame_cnt}, 32'd0);
    check_eq("rst_line_err", {31'd0, O_line_err}, 32'd0);
    check_eq("rst_frame_err", {31'd0, O_frame_err}, 32'd0);
    check_eq("rst_state", {30'd0, O_dbg_state}, {30'd0, S_IDLE});
    I_rst_n = 1'b1;
    gap(2);

    // start-up: two skipped frames, third boundary locks
    I_enable = 1'b1;
    I_mode   = 1'b0;
    drive_frame(S_SKIP, 0, 0, V, -1, -1, 0, 10'h0, 10'h0);
    drive_frame(S_SKIP, 0, 0, V, -1, -1, 0, 10'h0, 10'h0);
    drive_frame(S_RUN,  1, 0, V, -1, -1, 0, 10'h0, 10'h0);
    check_eq("cnt_first_run", {24'd0, O_frame_cnt}, 32'd0);
    check_eq("line_err_clean", {31'd0, O_line_err}, 32'd0);

    // RAW10 fixed patterns
    drive_frame(S_RUN, 1, 0, V, -1, -1, 1, 10'h3FF, 10'h0);
    check_eq("cnt_after_d", {24'd0, O_frame_cnt}, 32'd1);
    drive_frame(S_RUN, 1, 0, V, -1, -1, 1, 10'h200, 10'h0);
    check_eq("cnt_after_e", {24'd0, O_frame_cnt}, 32'd2);
    check_eq("frame_err_clean", {31'd0, O_frame_err}, 32'd0);

    // RGB565: fixed F8/1F then random bytes
    I_mode = 1'b1;
    drive_frame(S_RUN, 1, 1, V, -1, -1, 1, 10'h3E0, 10'h07C);
    check_eq("cnt_after_f", {24'd0, O_frame_cnt}, 32'd3);
    drive_frame(S_RUN, 1, 1, V, -1, -1, 0, 10'h0, 10'h0);
    check_eq("cnt_after_g", {24'd0, O_frame_cnt}, 32'd4);
    check_eq("line_err_rgb", {31'd0, O_line_err}, 32'd0);

    // short line -> line_err, frame with full line count keeps frame_err 0
    I_mode = 1'b0;
    drive_frame(S_RUN, 1, 0, V, 1, -1, 0, 10'h0, 10'h0);
    check_eq("line_err_set", {31'd0, O_line_err}, 32'd1);
    check_eq("frame_err_h", {31'd0, O_frame_err}, 32'd0);
    drive_frame(S_RUN, 1, 0, V, -1, -1, 0, 10'h0, 10'h0);
    check_eq("line_err_sticky", {31'd0, O_line_err}, 32'd1);
    check_eq("frame_err_i", {31'd0, O_frame_err}, 32'd0);
    check_eq("cnt_after_i", {24'd0, O_frame_cnt}, 32'd6);

    // short frame, flagged at the following boundary
    drive_frame(S_RUN, 1, 0, V - 1, -1, -1, 0, 10'h0, 10'h0);
    check_eq("frame_err_pending", {31'd0, O_frame_err}, 32'd0);
    drive_frame(S_RUN, 1, 0, V, -1, 2, 0, 10'h0, 10'h0);
    check_eq("frame_err_set", {31'd0, O_frame_err}, 32'd1);
    check_eq("cnt_after_k", {24'd0, O_frame_cnt}, 32'd8);

    // enable dropped during the previous frame: that frame completed, now idle
    drive_frame(S_IDLE, 0, 0, V, -1, -1, 0, 10'h0, 10'h0);
    check_eq("cnt_after_l", {24'd0, O_frame_cnt}, 32'd9);
    check_eq("idle_locked", {31'd0, O_locked}, 32'd0);

    // relock, then reset in the middle of a line
    I_enable = 1'b1;
    drive_frame(S_SKIP, 0, 0, V, -1, -1, 0, 10'h0, 10'h0);
    drive_frame(S_SKIP, 0, 0, V, -1, -1, 0, 10'h0, 10'h0);
    vsync_pulse(S_RUN);
    gap(2);
    drive_line(H, 1, 0, 0, 10'h0, 10'h0);
    gap(3);
    mon_en = 1'b0;
    drive_line(4, 0, 0, 0, 10'h0, 10'h0);
    #2;
    I_rst_n = 1'b0;
    #1;
    check_eq("mrst_de", {31'd0, fb_if.de}, 32'd0);
    check_eq("mrst_vs_n", {31'd0, fb_if.vs_n}, 32'd1);
    check_eq("mrst_frame_cnt", {24'd0, O_frame_cnt}, 32'd0);
    check_eq("mrst_locked", {31'd0, O_locked}, 32'd0);
    check_eq("mrst_line_err", {31'd0, O_line_err}, 32'd0);
    check_eq("mrst_frame_err", {31'd0, O_frame_err}, 32'd0);
    I_href    = 1'b0;
    I_vsync   = 1'b0;
    I_pixdata = '0;
    exp_q.delete();
    t_q.delete();
    repeat (2) @(negedge I_clk);
    I_rst_n = 1'b1;
    mon_en  = 1'b1;
    gap(2);

    // skip sequence repeats after reset
    drive_frame(S_SKIP, 0, 0, V, -1, -1, 0, 10'h0, 10'h0);
    drive_frame(S_SKIP, 0, 0, V, -1, -1, 0, 10'h0, 10'h0);
    drive_frame(S_RUN,  1, 0, V, -1, -1, 0, 10'h0, 10'h0);
    check_eq("cnt_rerun", {24'd0, O_frame_cnt}, 32'd0);
    vsync_pulse(S_RUN);
    gap(4);
    check_eq("cnt_final", {24'd0, O_frame_cnt}, 32'd1);
    check_eq("frame_err_final", {31'd0, O_frame_err}, 32'd0);
    check_eq("line_err_final", {31'd0, O_line_err}, 32'd0);
    check_eq("exp_q_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dvp_capture.md
Name: dvp_capture

Overview:
- Camera-side capture stage, directly upstream of the video frame buffer write port.
- Takes sensor DVP signals (VSYNC, HREF, 10-bit PIXDATA) sampled on the sensor pixel clock, which is wired to I_clk.
- Discards start-up frames and packs pixels to 16-bit RGB565.
- Emits frame-buffer input strobes (vs_n, de, data) plus frame/line/pixel status and error flags.

Parameters:
H_RES, 640, active pixels per line expected at output (after packing)
V_RES, 480, active lines per frame expected
SKIP_FRAMES, 2, complete frames discarded after enable before output starts (0 allowed)

Ports:
I_clk  in  1  sensor pixel clock; all logic on rising edge
I_rst_n  in  1  async active-low reset
I_enable  in  1  capture enable; sampled only at frame boundaries
I_mode  in  1  0: RAW10 mono, 1 px/clk; 1: RGB565 from 2 bytes/px (PIXDATA[9:2])
I_vsync  in  1  sensor VSYNC, active high
I_href  in  1  sensor HREF, active high during line data
I_pixdata  in  10  sensor pixel data
O_vs_n  out  1  frame sync to frame buffer, active low
O_de  out  1  output data valid
O_data  out  16  RGB565 pixel
O_locked  out  1  high while in RUN
O_frame_cnt  out  8  frames delivered, wraps 255->0
O_line_err  out  1  sticky: line with pixel count != H_RES
O_frame_err  out  1  sticky: frame with line count != V_RES

Behaviour:
- Reset: all outputs 0 except O_vs_n=1; FSM=IDLE; counters, phase and skip count 0.
- Inputs registered once (vs_d, href_d, pix_d). Frame boundary = rising edge of vs_d (vs_d=1, previous=0).
- FSM:
  - IDLE: at a frame boundary with I_enable=1 -> SKIP if SKIP_FRAMES>0, else RUN. Skip count cleared.
  - SKIP: skip count increments at each boundary; on boundary where count reaches SKIP_FRAMES -> RUN. I_enable=0 at any boundary -> IDLE.
  - RUN: at each boundary, I_enable=0 -> IDLE; otherwise stay.
  - Boundary entering RUN begins the first delivered frame.
- O_vs_n = ~vs_d only in RUN, else 1. O_de/O_data active only in RUN, href_d=1, vs_d=0.
- RAW10 mode:
  - Latency 2 clocks from I_pixdata to O_data.
  - O_de=1 every href_d cycle.
  - O_data = {p[9:5], p[9:4], p[9:5]} (grey replication).
- RGB565 mode:
  - Byte phase toggles each href_d cycle; cleared when href_d=0.
  - Phase 0 captures high byte b0=p[9:2].
  - Phase 1: O_de=1, O_data={b0, p[9:2]}.
  - Odd trailing byte at line end is dropped and counts as a short line.
- Line pixel counter (12 bit): counts O_de pulses; cleared on href_d falling edge.
  - At href_d falling edge in RUN: count != H_RES -> O_line_err=1.
  - A line counted there increments the 12-bit line counter; line counter cleared at boundary.
- At each boundary while already in RUN:
  - Line count != V_RES -> O_frame_err=1.
  - O_frame_cnt+1.
  - Boundary that enters RUN from IDLE/SKIP does neither.
- Error flags sticky until reset or a RUN entry from IDLE.
- Simultaneous href_d=1 and vs_d rising: boundary processed; that cycle's data suppressed (vs_d=1 gates de).
- Mode change mid-line: undefined data for that line; I_mode is meant to be static per frame, and the line is flagged by the count check.
- Async reset mid-frame: immediate return to reset values; capture resumes only after IDLE->SKIP sequence.
- Counter widths fixed at 12 bits; lines longer than 4095 px wrap and are flagged.

Test Plan:
- SKIP_FRAMES=2, mode 0, enable=1, three 640x480 frames -> O_de silent for frames 1–2; frame 3 gives 307200 de pulses; O_locked rises at 3rd boundary; flags 0.
- Mode 1, bytes 0xF8,0x1F per pixel (PIXDATA=byte<<2) -> O_data=16'hF81F, de every 2nd clock, 640 per line; O_frame_cnt increments 1 per frame after the first RUN frame.
- Mode 0, PIXDATA=10'h3FF -> O_data=16'hFFFF; PIXDATA=10'h200 -> 16'h8410; 2-clock latency checked.
- Inject one 639-pixel line -> O_line_err=1 and stays 1. Next frame boundary with 480 lines -> O_frame_err stays 0. A 479-line frame -> O_frame_err=1.
- Drop I_enable mid-frame -> current frame completes fully; at next boundary O_locked=0, O_vs_n=1, no further de.
- Assert I_rst_n low mid-line -> O_de=0, O_vs_n=1, O_frame_cnt=0 in same cycle. After release, SKIP_FRAMES frames are skipped again.
